ff_bank: RTL and testbench

Parametrised, edge-triggered successor of the lab's level-gated RS latch: a bank of `WIDTH` independent flip-flops sharing one clock, one enable and one run-time mode select (RS, JK, D, T). It is intended for the red experiment box's digital-logic lab set, where switches drive the inputs and LEDs show `Q`, `Q_n` and error indicators. Unlike the latch, the RS forbidden input (S=R=1) is detected, held off and reported rather than producing an undefined output.

---
 rtl/ff_bank.sv | 122 ++++++++++++
 tb/tb_ff_bank.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// ff_bank: WIDTH independent edge-triggered flip-flops, run-time selectable RS/JK/D/T,
// with RS forbidden-input detection. Define FF_BANK_ERR_CNT_EN to add the err_cnt counter.
module ff_bank #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Q_n,
    output logic [WIDTH-1:0]     illegal,
`ifdef FF_BANK_ERR_CNT_EN
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
`else
    output logic                 err_sticky
`endif
);

    typedef enum logic [1:0] {
        MODE_RS = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            mode_q;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] ill_r;
    logic             sticky_r;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] ill_next;
    logic             mode_chg;
    logic             upd;
    logic             set_err;

    // A mode switch costs one settle cycle: the new mode is only acted on once mode_q has caught up.
    assign mode_chg = (mode_e'(mode) != mode_q);
    assign upd      = en & ~mode_chg;
    assign set_err  = upd & (|ill_next);

    always_comb begin
        q_next   = q_r;
        ill_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_q)
                MODE_RS: begin
                    case ({a[i], b[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11:   ill_next[i] = 1'b1;
                        default: q_next[i] = q_r[i];
                    endcase
                end
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11:   q_next[i] = ~q_r[i];
                        default: q_next[i] = q_r[i];
                    endcase
                end
                MODE_D:  q_next[i] = a[i];
                MODE_T:  q_next[i] = q_r[i] ^ a[i];
                default: q_next[i] = q_r[i];
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q   <= MODE_RS;
            q_r      <= '0;
            ill_r    <= '0;
            sticky_r <= 1'b0;
        end else begin
            mode_q <= mode_e'(mode);
            if (upd) begin
                q_r <= q_next;
            end
            // illegal clears during settle even when disabled, otherwise holds while en=0
            if (mode_chg) begin
                ill_r <= '0;
            end else if (en) begin
                ill_r <= ill_next;
            end
            if (clr_err) begin
                sticky_r <= 1'b0;
            end else if (set_err) begin
                sticky_r <= 1'b1;
            end
        end
    end

`ifdef FF_BANK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= '0;
        end else if (clr_err) begin
            cnt_r <= '0;
        end else if (set_err && (cnt_r != {ERR_CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign err_cnt = cnt_r;
`endif

    assign Q          = q_r;
    assign Q_n        = ~q_r;
    assign illegal    = ill_r;
    assign err_sticky = sticky_r;

endmodule

// File: tb/tb_ff_bank.sv
// Self-checking bench for ff_bank: directed scenarios plus randomized traffic
// against a per-channel behavioural model.
module tb_ff_bank;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          CLK;
    logic          RST_N;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          clr_err;
    logic [W-1:0]  Q;
    logic [W-1:0]  Q_n;
    logic [W-1:0]  illegal;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    bit [W-1:0] m_q;
    bit [W-1:0] m_ill;
    bit         m_sticky;
    int         m_cnt;
    int         m_mode;

    ff_bank #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .en         (en),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .clr_err    (clr_err),
        .Q          (Q),
        .Q_n        (Q_n),
        .illegal    (illegal),
`ifdef FF_BANK_ERR_CNT_EN
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
`else
        .err_sticky (err_sticky)
`endif
    );

`ifndef FF_BANK_ERR_CNT_EN
    assign err_cnt = '0;
`endif

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        m_q = '0; m_ill = '0; m_sticky = 0; m_cnt = 0; m_mode = 0;
    endtask

    // One rising edge of the reference: rules applied channel by channel.
    task automatic model_step();
        bit any_ill;
        any_ill = 0;
        if (int'(mode) != m_mode) begin
            m_ill = '0;
        end else if (en) begin
            for (int i = 0; i < W; i++) begin
                bit ai, bi;
                ai = a[i]; bi = b[i];
                m_ill[i] = 0;
                if (m_mode == 0) begin
                    if (ai && bi) m_ill[i] = 1;
                    else if (ai) m_q[i] = 1;
                    else if (bi) m_q[i] = 0;
                end else if (m_mode == 1) begin
                    if (ai && bi) m_q[i] = !m_q[i];
                    else if (ai) m_q[i] = 1;
                    else if (bi) m_q[i] = 0;
                end else if (m_mode == 2) begin
                    m_q[i] = ai;
                end else begin
                    if (ai) m_q[i] = !m_q[i];
                end
            end
            any_ill = (m_ill != 0);
        end
        if (clr_err) begin
            m_sticky = 0;
            m_cnt    = 0;
        end else if (any_ill) begin
            m_sticky = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        m_mode = int'(mode);
    endtask

    // driver: advance one edge, update the model, settle away from the edge
    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        RST_N = 0; en = 0; mode = 2'b00; a = '0; b = '0; clr_err = 0;
        model_reset();
        #12;
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", Q); end
        n_checks++;
        if (Q_n !== 8'hFF) begin n_fail++; $display("FAIL reset_qn got %h want ff", Q_n); end
        n_checks++;
        if (err_sticky !== 1'b0 || illegal !== 8'h00) begin
            n_fail++; $display("FAIL reset_err got sticky=%b ill=%h want 0/00", err_sticky, illegal);
        end
`ifdef FF_BANK_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", err_cnt); end
`endif
        @(negedge CLK);
        RST_N = 1;
        mode = 2'b10; a = 8'hA5; en = 1;
        step();
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL d_settle got %h want 00", Q); end
        step();
        n_checks++;
        if (Q !== 8'hA5 || Q_n !== 8'h5A) begin
            n_fail++; $display("FAIL d_load got Q=%h Qn=%h want a5/5a", Q, Q_n);
        end
    endtask

    task automatic test_rs();
        a = 8'h00;
        step();
        mode = 2'b00; a = 8'h0F; b = 8'h00;
        step();
        step();
        n_checks++;
        if (Q !== 8'h0F) begin n_fail++; $display("FAIL rs_set got %h want 0f", Q); end
        a = 8'h03; b = 8'h03;
        step();
        n_checks++;
        if (Q !== 8'h0F || illegal !== 8'h03 || err_sticky !== 1'b1) begin
            n_fail++; $display("FAIL rs_illegal got Q=%h ill=%h st=%b want 0f/03/1", Q, illegal, err_sticky);
        end
`ifdef FF_BANK_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL rs_cnt got %0d want 1", err_cnt); end
`endif
    endtask

    task automatic test_jk();
        logic [W-1:0] exp_q[$];
        exp_q = '{8'hF0, 8'h0F, 8'hF0};
        mode = 2'b01; a = 8'hFF; b = 8'hFF;
        step();
        n_checks++;
        if (Q !== 8'h0F || illegal !== 8'h00) begin
            n_fail++; $display("FAIL jk_settle got Q=%h ill=%h want 0f/00", Q, illegal);
        end
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            step();
            n_checks++;
            if (Q !== e || illegal !== 8'h00) begin
                n_fail++; $display("FAIL jk_toggle got Q=%h ill=%h want %h/00", Q, illegal, e);
            end
        end
    endtask

    task automatic test_d_to_t();
        mode = 2'b10; a = 8'h01; b = 8'h00;
        step();
        step();
        n_checks++;
        if (Q !== 8'h01) begin n_fail++; $display("FAIL d_pre got %h want 01", Q); end
        mode = 2'b11;
        step();
        n_checks++;
        if (Q !== 8'h01) begin n_fail++; $display("FAIL t_settle got %h want 01", Q); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (Q !== ((k % 2 == 0) ? 8'h00 : 8'h01)) begin
                n_fail++; $display("FAIL t_toggle got %h want %h", Q, (k % 2 == 0) ? 8'h00 : 8'h01);
            end
        end
    endtask

    task automatic test_saturation();
        a = 8'h00; clr_err = 1;
        step();
        n_checks++;
        if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky got %b want 0", err_sticky); end
        clr_err = 0; mode = 2'b00; a = 8'h01; b = 8'h01;
        step();
        for (int k = 0; k < 5; k++) step();
        n_checks++;
        if (err_sticky !== 1'b1 || illegal !== 8'h01) begin
            n_fail++; $display("FAIL sat_flags got st=%b ill=%h want 1/01", err_sticky, illegal);
        end
`ifdef FF_BANK_ERR_CNT_EN
        n_checks++;
        if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d want 3", err_cnt); end
`endif
        clr_err = 1;
        step();
        clr_err = 0;
        n_checks++;
        if (err_sticky !== 1'b0 || err_cnt !== 2'd0) begin
            n_fail++; $display("FAIL clr_wins got st=%b cnt=%0d want 0/0", err_sticky, err_cnt);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] hq, hi;
        mode = 2'b00; a = 8'h30; b = 8'h10;
        step();
        a = 8'h42; b = 8'h42;
        step();
        hq = m_q; hi = m_ill;
        en = 0;
        for (int k = 0; k < 6; k++) begin
            a = W'($urandom); b = W'($urandom);
            step();
            n_checks++;
            if (Q !== hq || illegal !== hi) begin
                n_fail++; $display("FAIL en_hold got Q=%h ill=%h want %h/%h", Q, illegal, hq, hi);
            end
        end
        en = 1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            en      = ($urandom_range(0, 3) != 0);
            a       = W'($urandom);
            b       = W'($urandom);
            clr_err = ($urandom_range(0, 15) == 0);
            step();
            n_checks++;
            if (Q !== m_q || Q_n !== ~m_q || illegal !== m_ill || err_sticky !== m_sticky) begin
                n_fail++;
                $display("FAIL rand_%0d got Q=%h Qn=%h ill=%h st=%b want %h/%h/%h/%b",
                         k, Q, Q_n, illegal, err_sticky, m_q, ~m_q, m_ill, m_sticky);
            end
`ifdef FF_BANK_ERR_CNT_EN
            n_checks++;
            if (int'(err_cnt) != m_cnt) begin
                n_fail++; $display("FAIL rand_cnt_%0d got %0d want %0d", k, err_cnt, m_cnt);
            end
`endif
        end
        clr_err = 0;
    endtask

    task automatic test_async_reset();
        mode = 2'b10; en = 1; a = 8'hC3; b = 8'h00;
        step();
        step();
        #2;
        RST_N = 0;
        #1;
        model_reset();
        n_checks++;
        if (Q !== 8'h00 || Q_n !== 8'hFF || illegal !== 8'h00 || err_sticky !== 1'b0 || err_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL async_rst got Q=%h Qn=%h ill=%h st=%b cnt=%0d want 00/ff/00/0/0",
                     Q, Q_n, illegal, err_sticky, err_cnt);
        end
        @(negedge CLK);
        RST_N = 1;
        mode = 2'b00; a = 8'h00; b = 8'h00;
        step();
        n_checks++;
        if (Q !== 8'h00) begin n_fail++; $display("FAIL post_rst got %h want 00", Q); end
    endtask

    initial begin
        test_reset();
        test_rs();
        test_jk();
        test_d_to_t();
        test_saturation();
        test_hold();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
